drygascon128_seq: RTL and testbench
===================================

DRYGASCON128_SEQ -- requirements
Module: drygascon128_seq

Interface
REQ-001 clk  in  1  single clock; all state on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 cmd_valid  in  1  host command request.
REQ-004 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-005 cmd_op  in  3  0 LOAD_C, 1 LOAD_X, 2 F, 3 G, 4 READ_C; 5-7 illegal.
REQ-006 cmd_ds  in  4  domain separator for F.
REQ-007 cmd_rounds  in  4  round count for F/G.
REQ-008 s_valid  in  1  input word valid.
REQ-009 s_ready  out  1  input word accepted when high with s_valid.
REQ-010 s_data  in  32  input word, least-significant word first.
REQ-011 m_valid  out  1  output word valid.
REQ-012 m_ready  in  1  output word consumed when high with m_valid.
REQ-013 m_data  out  32  output word, least-significant word first.
REQ-014 err  out  1  one-cycle pulse on rejected command.
REQ-015 core_rst  out  1  synchronous active-high reset to the core.
REQ-016 core_din  out  32  core write data.
REQ-017 core_ds  out  4  core domain separator.
REQ-018 core_rounds  out  4  core round count.
REQ-019 core_wr_c / core_wr_x / core_wr_i  out  1 each  core write strobes.
REQ-020 core_start  out  1  core start strobe.
REQ-021 core_rd_c / core_rd_r  out  1 each  core read strobes.
REQ-022 core_dout  in  32  core registered read data, valid one cycle after a read strobe.
REQ-023 core_idle  in  1  core idle flag; the core's clk_en is tied high.

Function
REQ-024 States SHALL be IDLE, WRITE, START, WAIT, READ.
REQ-025 cmd_ready SHALL be 1 only in IDLE with core_idle=1 and core_rst=0.
REQ-026 On accept, op, ds and rounds SHALL be latched; core_ds and core_rounds SHALL drive the latched values, stable until IDLE is re-entered.
REQ-027 Illegal op, or rounds=0 with F/G, SHALL pulse err for 1 cycle, stay in IDLE and issue no core strobe.
REQ-028 Word counts SHALL be: LOAD_C 10 writes; LOAD_X 4 writes; F 4 writes then 4 reads; G 0 writes then 4 reads; READ_C 10 reads.
REQ-029 WRITE: s_ready=1; each s_valid&s_ready cycle SHALL assert exactly the op's strobe (wr_c/wr_x/wr_i) combinationally, with core_din=s_data.
REQ-030 After the last write, LOAD_C/LOAD_X SHALL return to IDLE and F SHALL go to START; G and READ_C SHALL go from accept directly to START and READ respectively.
REQ-031 START SHALL assert core_start for exactly 1 cycle, then go to WAIT.
REQ-032 WAIT SHALL hold until core_idle=1, then go to READ.
REQ-033 READ SHALL assert rd_r (F/G) or rd_c (READ_C) for 1 cycle only when m_valid=0 and no read is pending.
REQ-034 The cycle after a read strobe, core_dout SHALL be captured into m_data and m_valid set; m_valid SHALL hold with m_data stable until m_ready.
REQ-035 After the last word handshake the block SHALL return to IDLE.
REQ-036 At most one core strobe SHALL be high in any cycle; all strobes SHALL be 0 outside WRITE, START and READ.
REQ-037 s_ready SHALL be 0 outside WRITE; the count of words written or read per op SHALL be exact, so the core word counter ends at 0.

Reset
REQ-038 While rst_n=0: state IDLE, counters 0, core_rst=1, and all other outputs 0 (including m_data, core_ds, core_rounds).
REQ-039 core_rst SHALL deassert on the second rising edge after rst_n rises (synchronous release); cmd_ready SHALL stay 0 until then.
REQ-040 rst_n low mid-operation SHALL abort immediately with no further strobes; core state is reset through core_rst.

Verification
REQ-041 LOAD_C with 10 words 0x0..0x9, then READ_C -> wr_c pulses 10 times; m_data returns 0x0..0x9 in order.
REQ-042 F with ds=0x5, rounds=7, 4 I words -> 4 wr_i pulses, 1 core_start, wait for idle, 4 rd_r; m_data matches the golden model; core_ds=0x5 throughout.
REQ-043 G with rounds=11 and m_ready low for 5 cycles per word -> no second rd_r while m_valid=1; m_data stable until the handshake.
REQ-044 cmd_op=6, and separately F with rounds=0 -> err 1-cycle pulse, no core strobes, cmd_ready back to 1 the next cycle.
REQ-045 rst_n pulled low during WAIT of F -> outputs 0, core_rst=1; after release, core_rst drops 2 edges later; a new LOAD_X completes normally.

Source files
------------

// File: rtl/drygascon128_seq.sv
// Command sequencer for a DryGASCON128 core: decodes host commands into core
// write/start/read strobes and moves 32-bit words between the host streams and the core.
module drygascon128_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [3:0]  cmd_ds,
  input  logic [3:0]  cmd_rounds,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        err,
  output logic        core_rst,
  output logic [31:0] core_din,
  output logic [3:0]  core_ds,
  output logic [3:0]  core_rounds,
  output logic        core_wr_c,
  output logic        core_wr_x,
  output logic        core_wr_i,
  output logic        core_start,
  output logic        core_rd_c,
  output logic        core_rd_r,
  input  logic [31:0] core_dout,
  input  logic        core_idle
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DS_W   = 4;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_LOAD_C = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOAD_X = OP_W'(1);
  localparam logic [OP_W-1:0] OP_F      = OP_W'(2);
  localparam logic [OP_W-1:0] OP_G      = OP_W'(3);
  localparam logic [OP_W-1:0] OP_READ_C = OP_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_START,
    ST_WAIT,
    ST_READ
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DS_W-1:0]     ds_q, ds_d;
  logic [RND_W-1:0]    rounds_q, rounds_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                err_q, err_d;
  logic                sync_q;
  logic                core_rst_q;
  logic [CNT_W-1:0]    wr_last;
  logic [CNT_W-1:0]    rd_last;

  // The C state is 10 words; X, I and R are 4 words each
  assign wr_last = (op_q == OP_LOAD_C) ? CNT_W'(9) : CNT_W'(3);
  assign rd_last = (op_q == OP_READ_C) ? CNT_W'(9) : CNT_W'(3);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ds_d        = ds_q;
    rounds_d    = rounds_q;
    cnt_d       = cnt_q;
    rd_pend_d   = 1'b0;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    err_d       = 1'b0;
    cmd_ready   = 1'b0;
    s_ready     = 1'b0;
    core_din    = '0;
    core_wr_c   = 1'b0;
    core_wr_x   = 1'b0;
    core_wr_i   = 1'b0;
    core_start  = 1'b0;
    core_rd_c   = 1'b0;
    core_rd_r   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = core_idle && !core_rst_q;
        if (cmd_valid && cmd_ready) begin
          if (cmd_op > OP_READ_C ||
              ((cmd_op == OP_F || cmd_op == OP_G) && cmd_rounds == '0)) begin
            err_d = 1'b1;
          end else begin
            op_d     = cmd_op;
            ds_d     = cmd_ds;
            rounds_d = cmd_rounds;
            cnt_d    = '0;
            case (cmd_op)
              OP_G:      state_d = ST_START;
              OP_READ_C: state_d = ST_READ;
              default:   state_d = ST_WRITE;
            endcase
          end
        end
      end
      ST_WRITE: begin
        s_ready  = 1'b1;
        core_din = s_data;
        if (s_valid) begin
          core_wr_c = (op_q == OP_LOAD_C);
          core_wr_x = (op_q == OP_LOAD_X);
          core_wr_i = (op_q == OP_F);
          if (cnt_q == wr_last) begin
            cnt_d   = '0;
            state_d = (op_q == OP_F) ? ST_START : ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_START: begin
        core_start = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_idle) state_d = ST_READ;
      end
      ST_READ: begin
        // One read in flight at a time; the next issues only once the output slot is free
        if (!m_valid_q && !rd_pend_q) begin
          core_rd_c = (op_q == OP_READ_C);
          core_rd_r = (op_q != OP_READ_C);
          rd_pend_d = 1'b1;
        end
        if (rd_pend_q) begin
          m_valid_d = 1'b1;
          m_data_d  = core_dout;
        end
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          if (cnt_q == rd_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      ds_q       <= '0;
      rounds_q   <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      err_q      <= 1'b0;
      sync_q     <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ds_q       <= ds_d;
      rounds_q   <= rounds_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      err_q      <= err_d;
      sync_q     <= 1'b1;
      core_rst_q <= !sync_q;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign err         = err_q;
  assign core_rst    = core_rst_q;
  assign core_ds     = ds_q;
  assign core_rounds = rounds_q;

endmodule

// File: tb/tb_drygascon128_seq.sv
// Bench for drygascon128_seq: a behavioural stand-in core, directed commands,
// and a queue scoreboard checking every output word handshake.
module tb_drygascon128_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_ds = '0;
  logic [3:0]  cmd_rounds = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        err;
  logic        core_rst;
  logic [31:0] core_din;
  logic [3:0]  core_ds;
  logic [3:0]  core_rounds;
  logic        core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_c, core_rd_r;
  logic [31:0] core_dout = '0;
  logic        core_idle;

  drygascon128_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ds(cmd_ds), .cmd_rounds(cmd_rounds),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err(err), .core_rst(core_rst), .core_din(core_din),
    .core_ds(core_ds), .core_rounds(core_rounds),
    .core_wr_c(core_wr_c), .core_wr_x(core_wr_x), .core_wr_i(core_wr_i),
    .core_start(core_start), .core_rd_c(core_rd_c), .core_rd_r(core_rd_r),
    .core_dout(core_dout), .core_idle(core_idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mix(input logic [31:0] c, input logic [31:0] x,
                                      input logic [31:0] i, input logic [3:0] ds,
                                      input logic [3:0] rnd, input int k);
    return c ^ x ^ i ^ {ds, rnd, 24'h0} ^ 32'(k);
  endfunction

  // Stand-in core: registered reads, busy for rounds+3 cycles after start, I cleared on start
  logic [31:0] cm_c[10];
  logic [31:0] cm_x[4];
  logic [31:0] cm_i[4];
  logic [31:0] cm_r[4];
  int cm_wc = 0, cm_wx = 0, cm_wi = 0, cm_rc = 0, cm_rr = 0, cm_busy = 0;
  assign core_idle = (cm_busy == 0);

  always @(posedge clk) begin
    if (core_rst) begin
      for (int k = 0; k < 10; k++) cm_c[k] <= '0;
      for (int k = 0; k < 4; k++) begin
        cm_x[k] <= '0; cm_i[k] <= '0; cm_r[k] <= '0;
      end
      cm_wc <= 0; cm_wx <= 0; cm_wi <= 0; cm_rc <= 0; cm_rr <= 0;
      cm_busy <= 0; core_dout <= '0;
    end else begin
      if (core_wr_c) begin cm_c[cm_wc] <= core_din; cm_wc <= (cm_wc + 1) % 10; end
      if (core_wr_x) begin cm_x[cm_wx] <= core_din; cm_wx <= (cm_wx + 1) % 4; end
      if (core_wr_i) begin cm_i[cm_wi] <= core_din; cm_wi <= (cm_wi + 1) % 4; end
      if (core_start) begin
        for (int k = 0; k < 4; k++) begin
          cm_r[k] <= mix(cm_c[k], cm_x[k], cm_i[k], core_ds, core_rounds, k);
          cm_i[k] <= '0;
        end
        cm_busy <= int'(core_rounds) + 3;
      end else if (cm_busy != 0) begin
        cm_busy <= cm_busy - 1;
      end
      if (core_rd_c) begin
        core_dout <= cm_c[cm_rc]; cm_rc <= (cm_rc + 1) % 10;
      end else if (core_rd_r) begin
        core_dout <= cm_r[cm_rr]; cm_rr <= (cm_rr + 1) % 4;
      end
    end
  end

  // Strobe accounting and protocol checks
  int cnt_wc = 0, cnt_wx = 0, cnt_wi = 0, cnt_st = 0, cnt_rc = 0, cnt_rr = 0, cnt_all = 0;
  bit chk_cfg = 1'b0;
  logic [3:0] exp_ds = '0, exp_rounds = '0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_d = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      n = int'(core_wr_c) + int'(core_wr_x) + int'(core_wr_i) +
          int'(core_start) + int'(core_rd_c) + int'(core_rd_r);
      if (n != 0) begin
        check("one_strobe", 32'(n), 32'd1);
        cnt_all++;
        if (core_wr_c) cnt_wc++;
        if (core_wr_x) cnt_wx++;
        if (core_wr_i) cnt_wi++;
        if (core_start) cnt_st++;
        if (core_rd_c) cnt_rc++;
        if (core_rd_r) cnt_rr++;
        if (core_wr_c || core_wr_x || core_wr_i) check("core_din", core_din, s_data);
        if (chk_cfg) begin
          check("core_ds", 32'(core_ds), 32'(exp_ds));
          check("core_rounds", 32'(core_rounds), 32'(exp_rounds));
        end
      end
      if (m_valid) check("no_rd_while_valid", 32'(core_rd_c | core_rd_r), 32'd0);
      if (m_valid && prev_v && !prev_r) check("m_data_stable", m_data, prev_d);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", m_data, 32'hFFFF_FFFF ^ m_data);
        else check("m_data", m_data, exp_q.pop_front());
      end
      prev_v = m_valid; prev_r = m_ready; prev_d = m_data;
    end
  end

  // Output sink: holds m_ready low for `stall` cycles of each valid word
  int stall = 0;
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge clk); #1;
      if (!m_valid) begin hold = 0; m_ready = 1'b0; end
      else begin m_ready = (hold >= stall); hold++; end
    end
  end

  task automatic send_cmd(input logic [2:0] op, input logic [3:0] ds, input logic [3:0] rnd);
    bit acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_ds = ds; cmd_rounds = rnd;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) check("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!acc) check("word_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = cmd_ready && (exp_q.size() == 0);
    end
    check("op_complete", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] xw[4];
    logic [31:0] iw[4];
    xw[0] = 32'h1111_1111; xw[1] = 32'h2222_2222; xw[2] = 32'h3333_3333; xw[3] = 32'h4444_4444;
    iw[0] = 32'hDEAD_BEEF; iw[1] = 32'h0123_4567; iw[2] = 32'h89AB_CDEF; iw[3] = 32'h0F0F_0F0F;

    // Reset values and synchronous core_rst release
    repeat (3) @(posedge clk); #1;
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_core_ds", 32'(core_ds), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_edge1_core_rst", 32'(core_rst), 32'd1);
    check("rel_edge1_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_edge2_core_rst", 32'(core_rst), 32'd0);
    check("rel_edge2_cmd_ready", 32'(cmd_ready), 32'd1);

    // LOAD_C 0..9 then READ_C
    send_cmd(3'd0, 4'd0, 4'd0);
    for (int k = 0; k < 10; k++) send_word(32'(k));
    wait_done();
    check("loadc_wr_c", 32'(cnt_wc), 32'd10);
    for (int k = 0; k < 10; k++) exp_q.push_back(32'(k));
    send_cmd(3'd4, 4'd0, 4'd0);
    wait_done();
    check("readc_rd_c", 32'(cnt_rc), 32'd10);

    // LOAD_X, then F with ds=5 rounds=7
    send_cmd(3'd1, 4'd0, 4'd0);
    for (int k = 0; k < 4; k++) send_word(xw[k]);
    wait_done();
    check("loadx_wr_x", 32'(cnt_wx), 32'd4);
    exp_ds = 4'h5; exp_rounds = 4'd7; chk_cfg = 1'b1;
    exp_q.push_back(32'h98BC_AFFE);
    exp_q.push_back(32'h7401_6745);
    exp_q.push_back(32'hED98_FEDC);
    exp_q.push_back(32'h1C4B_4B4B);
    send_cmd(3'd2, 4'h5, 4'd7);
    for (int k = 0; k < 4; k++) send_word(iw[k]);
    wait_done();
    check("f_wr_i", 32'(cnt_wi), 32'd4);
    check("f_start", 32'(cnt_st), 32'd1);
    check("f_rd_r", 32'(cnt_rr), 32'd4);

    // G with rounds=11 and a slow consumer
    exp_ds = 4'h3; exp_rounds = 4'd11; stall = 5;
    exp_q.push_back(32'h2A11_1111);
    exp_q.push_back(32'h1922_2222);
    exp_q.push_back(32'h0833_3333);
    exp_q.push_back(32'h7F44_4444);
    send_cmd(3'd3, 4'h3, 4'd11);
    wait_done();
    check("g_start", 32'(cnt_st), 32'd2);
    check("g_rd_r", 32'(cnt_rr), 32'd8);
    stall = 0; chk_cfg = 1'b0;

    // Rejected commands
    base = cnt_all;
    send_cmd(3'd6, 4'd0, 4'd3);
    check("err_op6_pulse", 32'(err), 32'd1);
    @(posedge clk); #1;
    check("err_op6_clear", 32'(err), 32'd0);
    check("err_op6_ready", 32'(cmd_ready), 32'd1);
    send_cmd(3'd2, 4'd1, 4'd0);
    check("err_r0_pulse", 32'(err), 32'd1);
    check("err_r0_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("err_r0_clear", 32'(err), 32'd0);
    check("err_r0_ready", 32'(cmd_ready), 32'd1);
    check("err_no_strobes", 32'(cnt_all - base), 32'd0);

    // Reset during WAIT of an F
    base = cnt_st;
    exp_ds = 4'h9; exp_rounds = 4'd15; chk_cfg = 1'b1;
    send_cmd(3'd2, 4'h9, 4'd15);
    for (int k = 0; k < 4; k++) send_word(32'hCAFE_0000 + 32'(k));
    for (int t = 0; t < 100 && cnt_st == base; t++) @(negedge clk);
    check("abort_started", 32'(cnt_st - base), 32'd1);
    @(posedge clk);
    repeat (2) @(posedge clk);
    chk_cfg = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_core_rst", 32'(core_rst), 32'd1);
    check("abort_core_ds", 32'(core_ds), 32'd0);
    check("abort_core_rounds", 32'(core_rounds), 32'd0);
    check("abort_m_data", m_data, 32'd0);
    check("abort_strobes", 32'({core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_c, core_rd_r}), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    base = cnt_all;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_rel_edge1", 32'(core_rst), 32'd1);
    @(posedge clk); #1;
    check("abort_rel_edge2", 32'(core_rst), 32'd0);
    check("abort_no_strobes", 32'(cnt_all - base), 32'd0);

    // New LOAD_X after reset, then G to read it back through a freshly reset core
    base = cnt_wx;
    send_cmd(3'd1, 4'd0, 4'd0);
    send_word(32'hA0A0_A0A0); send_word(32'hB0B0_B0B0);
    send_word(32'hC0C0_C0C0); send_word(32'hD0D0_D0D0);
    wait_done();
    check("post_rst_wr_x", 32'(cnt_wx - base), 32'd4);
    exp_q.push_back(32'hA1A0_A0A0);
    exp_q.push_back(32'hB1B0_B0B1);
    exp_q.push_back(32'hC1C0_C0C2);
    exp_q.push_back(32'hD1D0_D0D3);
    send_cmd(3'd3, 4'h0, 4'd1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
